time_keeper: RTL and testbench

Timekeeping and alarm core for the alarm clock, directly downstream of the clock divider. Takes the divider's toggling 1 Hz square wave, synchronises and edge-detects it into a single-cycle second strobe, and maintains the HH:MM:SS time of day and a HH:MM alarm. Runs an alarm state machine with ring timeout and snooze. Outputs feed the display/BCD stage and the buzzer driver.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/time_keeper_if.sv | 30 +++
 rtl/edge_sync.sv | 28 ++
 rtl/time_keeper.sv | 164 ++++++++++++++++
 tb/tb_time_keeper.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared encodings and limits for the alarm-clock timekeeping core.
package alarm_pkg;

  typedef enum logic [1:0] {
    ModeRun      = 2'b00,
    ModeSetTime  = 2'b01,
    ModeSetAlarm = 2'b10,
    ModeRunAlt   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRinging = 2'b01,
    StSnoozed = 2'b10
  } alarm_state_e;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_SEC  = 59;

  // Modular increment: returns 0 once val has reached max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input int unsigned max);
    return (val == 6'(max)) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Control inputs and time/alarm outputs of the timekeeping core.
interface time_keeper_if;
  import alarm_pkg::*;

  mode_e      mode;
  logic       inc_hr;
  logic       inc_min;
  logic       alarm_en;
  logic       snooze;
  logic       stop;

  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       ringing;
  logic       sec_tick;

  modport master (
    output mode, inc_hr, inc_min, alarm_en, snooze, stop,
    input  hours, minutes, seconds, alarm_hours, alarm_minutes, ringing, sec_tick
  );

  modport slave (
    input  mode, inc_hr, inc_min, alarm_en, snooze, stop,
    output hours, minutes, seconds, alarm_hours, alarm_minutes, ringing, sec_tick
  );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a rising-edge detector; the reset value is chosen so that
// releasing reset with the input already high does not look like an edge.
module edge_sync #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s2_q, p_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= ResetVal;
      s2_q <= ResetVal;
      p_q  <= ResetVal;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      p_q  <= s2_q;
    end
  end

  assign rise = s2_q & ~p_q;

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter, alarm registers and ring/snooze state machine, advanced by the
// synchronised 1 Hz strobe from the clock divider.
module time_keeper
  import alarm_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sec_clk,
  time_keeper_if.slave  bus
);

  localparam int unsigned SnzLoad = SNOOZE_MIN * 60;
  localparam int unsigned RingW   = $clog2(ALARM_SECS + 1);
  localparam int unsigned SnzW    = $clog2(SnzLoad + 1);

  logic sec_tick;

  edge_sync #(
    .ResetVal (1'b1)
  ) u_sec_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sec_clk),
    .rise     (sec_tick)
  );

  logic [4:0]      hours_q, hours_d, al_hours_q, al_hours_d, adv_hours;
  logic [5:0]      minutes_q, minutes_d, al_minutes_q, al_minutes_d, adv_minutes;
  logic [5:0]      seconds_q, seconds_d, adv_seconds;
  logic            set_time, set_alarm, commit, alarm_match;
  alarm_state_e    state_q;
  logic [RingW-1:0] ring_cnt_q, ring_nxt;
  logic [SnzW-1:0]  snz_cnt_q, snz_nxt;

  always_comb begin
    set_time  = (bus.mode == ModeSetTime);
    set_alarm = (bus.mode == ModeSetAlarm);
    commit    = sec_tick && !set_time;
  end

  // Time of day one second later, with carries.
  always_comb begin
    adv_seconds = wrap_inc(seconds_q, MAX_SEC);
    adv_minutes = minutes_q;
    adv_hours   = hours_q;
    if (seconds_q == 6'(MAX_SEC)) begin
      adv_minutes = wrap_inc(minutes_q, MAX_MIN);
      if (minutes_q == 6'(MAX_MIN)) begin
        adv_hours = 5'(wrap_inc({1'b0, hours_q}, MAX_HOUR));
      end
    end
  end

  always_comb begin
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    al_hours_d   = al_hours_q;
    al_minutes_d = al_minutes_q;

    if (set_time) begin
      seconds_d = '0;
      if (bus.inc_hr) begin
        hours_d = 5'(wrap_inc({1'b0, hours_q}, MAX_HOUR));
      end
      if (bus.inc_min) begin
        minutes_d = wrap_inc(minutes_q, MAX_MIN);
      end
    end else if (commit) begin
      hours_d   = adv_hours;
      minutes_d = adv_minutes;
      seconds_d = adv_seconds;
    end

    if (set_alarm) begin
      if (bus.inc_hr) begin
        al_hours_d = 5'(wrap_inc({1'b0, al_hours_q}, MAX_HOUR));
      end
      if (bus.inc_min) begin
        al_minutes_d = wrap_inc(al_minutes_q, MAX_MIN);
      end
    end
  end

  // Match on the value being committed so ringing rises on the same edge as the time.
  always_comb begin
    alarm_match = commit && (adv_seconds == 6'd0) &&
                  (adv_hours == al_hours_q) && (adv_minutes == al_minutes_q);
    ring_nxt    = ring_cnt_q + RingW'(1);
    snz_nxt     = snz_cnt_q - SnzW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hours_q      <= '0;
      minutes_q    <= '0;
      seconds_q    <= '0;
      al_hours_q   <= '0;
      al_minutes_q <= '0;
    end else begin
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      al_hours_q   <= al_hours_d;
      al_minutes_q <= al_minutes_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else if (!bus.alarm_en || set_time) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (alarm_match) begin
            state_q    <= StRinging;
            ring_cnt_q <= '0;
          end
        end
        StRinging: begin
          if (bus.stop) begin
            state_q <= StIdle;
          end else if (bus.snooze) begin
            state_q   <= StSnoozed;
            snz_cnt_q <= SnzW'(SnzLoad);
          end else if (sec_tick) begin
            ring_cnt_q <= ring_nxt;
            if (ring_nxt == RingW'(ALARM_SECS)) begin
              state_q <= StIdle;
            end
          end
        end
        StSnoozed: begin
          if (bus.stop) begin
            state_q <= StIdle;
          end else if (sec_tick) begin
            snz_cnt_q <= snz_nxt;
            if (snz_nxt == '0) begin
              state_q    <= StRinging;
              ring_cnt_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.hours         = hours_q;
  assign bus.minutes       = minutes_q;
  assign bus.seconds       = seconds_q;
  assign bus.alarm_hours   = al_hours_q;
  assign bus.alarm_minutes = al_minutes_q;
  assign bus.ringing       = (state_q == StRinging);
  assign bus.sec_tick      = sec_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a seconds-of-day model checked every cycle, plus
// literal expectations at the interesting points of each scenario.
module tb_time_keeper;
  import alarm_pkg::*;

  localparam int AlarmSecs = 60;
  localparam int SnoozeMin = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sec_clk = 1'b1;

  time_keeper_if bus ();

  time_keeper #(
    .ALARM_SECS (AlarmSecs),
    .SNOOZE_MIN (SnoozeMin)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sec_clk (sec_clk),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time as seconds since midnight, alarm as minutes since midnight.
  int m_tod, m_alm, m_st, m_ring, m_snz, ntod, h, mi;
  bit m_h1, m_h2, m_h3, m_tick, m_valid, settime, setalarm, match;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_tod = 0; m_alm = 0; m_st = 0; m_ring = 0; m_snz = 0;
      m_h1 = 1; m_h2 = 1; m_h3 = 1;
      m_valid = 1'b1;
    end else begin
      settime  = (bus.mode == ModeSetTime);
      setalarm = (bus.mode == ModeSetAlarm);
      ntod = m_tod;
      if (settime) begin
        h  = m_tod / 3600;
        mi = (m_tod / 60) % 60;
        if (bus.inc_hr) h = (h + 1) % 24;
        if (bus.inc_min) mi = (mi + 1) % 60;
        ntod = h * 3600 + mi * 60;
      end else if (m_tick) begin
        ntod = (m_tod + 1) % 86400;
      end
      match = m_tick && !settime && (ntod % 60 == 0) && (ntod / 60 == m_alm);
      if (setalarm) begin
        h  = m_alm / 60;
        mi = m_alm % 60;
        if (bus.inc_hr) h = (h + 1) % 24;
        if (bus.inc_min) mi = (mi + 1) % 60;
        m_alm = h * 60 + mi;
      end
      if (!bus.alarm_en || settime) begin
        m_st = 0;
      end else if (m_st == 0) begin
        if (match) begin m_st = 1; m_ring = 0; end
      end else if (m_st == 1) begin
        if (bus.stop) m_st = 0;
        else if (bus.snooze) begin m_st = 2; m_snz = SnoozeMin * 60; end
        else if (m_tick) begin
          m_ring++;
          if (m_ring == AlarmSecs) m_st = 0;
        end
      end else begin
        if (bus.stop) m_st = 0;
        else if (m_tick) begin
          m_snz--;
          if (m_snz == 0) begin m_st = 1; m_ring = 0; end
        end
      end
      m_tod = ntod;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = sec_clk;
    end
    m_tick = m_h2 && !m_h3;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("hours", int'(bus.hours), m_tod / 3600);
      check("minutes", int'(bus.minutes), (m_tod / 60) % 60);
      check("seconds", int'(bus.seconds), m_tod % 60);
      check("alarm_hours", int'(bus.alarm_hours), m_alm / 60);
      check("alarm_minutes", int'(bus.alarm_minutes), m_alm % 60);
      check("sec_tick", int'(bus.sec_tick), int'(m_tick));
      check("ringing", int'(bus.ringing), int'(m_st == 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_inc(input bit hr, input bit mn);
    bus.inc_hr  = hr;
    bus.inc_min = mn;
    cyc(1);
    bus.inc_hr  = 1'b0;
    bus.inc_min = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sec_clk = 1'b1;
      cyc(4);
      sec_clk = 1'b0;
      cyc(4);
    end
  endtask

  initial begin
    bus.mode = ModeRun;
    bus.inc_hr = 1'b0; bus.inc_min = 1'b0;
    bus.alarm_en = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);
    check("lit_reset_tick", int'(bus.sec_tick), 0);
    check("lit_reset_time", int'(bus.hours) + int'(bus.minutes) + int'(bus.seconds), 0);
    check("lit_reset_ring", int'(bus.ringing), 0);
    sec_clk = 1'b0;
    cyc(4);

    // Set the time, including ticks that must be ignored and wrap of minutes.
    bus.mode = ModeSetTime;
    for (int i = 0; i < 23; i++) pulse_inc(1'b1, 1'b0);
    for (int i = 0; i < 59; i++) pulse_inc(1'b0, 1'b1);
    ticks(3);
    check("lit_set_sec0", int'(bus.seconds), 0);
    check("lit_set_hr", int'(bus.hours), 23);
    check("lit_set_min", int'(bus.minutes), 59);
    pulse_inc(1'b0, 1'b1);
    check("lit_minwrap_min", int'(bus.minutes), 0);
    check("lit_minwrap_hr", int'(bus.hours), 23);
    pulse_inc(1'b1, 1'b1);
    check("lit_both_hr", int'(bus.hours), 0);
    check("lit_both_min", int'(bus.minutes), 1);
    for (int i = 0; i < 23; i++) pulse_inc(1'b1, 1'b0);
    for (int i = 0; i < 58; i++) pulse_inc(1'b0, 1'b1);

    // Run across midnight, checking tick latency on the first second.
    bus.mode = ModeRun;
    sec_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lit_tick_early", int'(bus.sec_tick), 0);
    @(negedge clk);
    check("lit_tick_lat", int'(bus.sec_tick), 1);
    @(negedge clk);
    check("lit_sec_after_tick", int'(bus.seconds), 1);
    @(posedge clk);
    #1;
    sec_clk = 1'b0;
    cyc(4);
    ticks(59);
    check("lit_midnight", int'(bus.hours) * 3600 + int'(bus.minutes) * 60 + int'(bus.seconds), 0);

    // Alarm 06:30, time 06:29:59, then ring and time out.
    bus.mode = ModeSetAlarm;
    for (int i = 0; i < 6; i++) pulse_inc(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) pulse_inc(1'b0, 1'b1);
    check("lit_alarm_hr", int'(bus.alarm_hours), 6);
    check("lit_alarm_min", int'(bus.alarm_minutes), 30);
    bus.mode = ModeSetTime;
    for (int i = 0; i < 6; i++) pulse_inc(1'b1, 1'b0);
    for (int i = 0; i < 29; i++) pulse_inc(1'b0, 1'b1);
    bus.mode = ModeRun;
    bus.alarm_en = 1'b1;
    ticks(59);
    check("lit_pre_ring", int'(bus.ringing), 0);
    ticks(1);
    check("lit_ring_on", int'(bus.ringing), 1);
    check("lit_ring_time", int'(bus.hours) * 100 + int'(bus.minutes), 630);
    ticks(AlarmSecs - 1);
    check("lit_ring_last", int'(bus.ringing), 1);
    ticks(1);
    check("lit_ring_timeout", int'(bus.ringing), 0);

    // Alarm 06:32: stop and snooze together go idle.
    bus.mode = ModeSetAlarm;
    pulse_inc(1'b0, 1'b1);
    pulse_inc(1'b0, 1'b1);
    bus.mode = ModeRun;
    ticks(60);
    check("lit_ring2_on", int'(bus.ringing), 1);
    bus.snooze = 1'b1; bus.stop = 1'b1;
    cyc(1);
    bus.snooze = 1'b0; bus.stop = 1'b0;
    check("lit_stop_wins", int'(bus.ringing), 0);
    ticks(5);

    // Alarm 06:33: snooze for 300 ticks then re-ring.
    bus.mode = ModeSetAlarm;
    pulse_inc(1'b0, 1'b1);
    bus.mode = ModeRun;
    ticks(55);
    check("lit_ring3_on", int'(bus.ringing), 1);
    bus.snooze = 1'b1;
    cyc(1);
    bus.snooze = 1'b0;
    check("lit_snoozed", int'(bus.ringing), 0);
    ticks(SnoozeMin * 60 - 1);
    check("lit_snooze_299", int'(bus.ringing), 0);
    ticks(1);
    check("lit_snooze_rering", int'(bus.ringing), 1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check("lit_stop", int'(bus.ringing), 0);

    // Alarm 06:39: disarm while snoozed, run in mode 11.
    bus.mode = ModeSetAlarm;
    for (int i = 0; i < 6; i++) pulse_inc(1'b0, 1'b1);
    bus.mode = ModeRun;
    ticks(60);
    check("lit_ring4_on", int'(bus.ringing), 1);
    bus.snooze = 1'b1;
    cyc(1);
    bus.snooze = 1'b0;
    ticks(10);
    bus.alarm_en = 1'b0;
    cyc(1);
    bus.mode = ModeRunAlt;
    ticks(SnoozeMin * 60);
    check("lit_disarm_no_ring", int'(bus.ringing), 0);
    check("lit_time_64410",
          int'(bus.hours) * 10000 + int'(bus.minutes) * 100 + int'(bus.seconds), 64410);

    // Alarm 06:45: reset while ringing.
    bus.alarm_en = 1'b1;
    bus.mode = ModeSetAlarm;
    for (int i = 0; i < 6; i++) pulse_inc(1'b0, 1'b1);
    bus.mode = ModeRun;
    ticks(50);
    check("lit_ring5_on", int'(bus.ringing), 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("lit_rst_ring", int'(bus.ringing), 0);
    check("lit_rst_alarm", int'(bus.alarm_minutes), 0);
    check("lit_rst_hours", int'(bus.hours), 0);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
